rl_ram_arb: RTL and testbench
=============================

RL_RAM_ARB -- requirements
Module: rl_ram_arb

Interface
REQ-001 SHALL have parameter ABITS, default 10, RAM word-address width.
REQ-002 SHALL have parameter DBITS, default 32, RAM data width; BBITS=(DBITS+7)/8 byte enables.
REQ-003 SHALL have ports: clk_i in 1 clock; rst_ni in 1 reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have, for each requester n in {0,1}: req<n>_i in 1 request; addr<n>_i in ABITS word address; we<n>_i in 1 write; be<n>_i in BBITS byte enables; wdata<n>_i in DBITS write data.
REQ-005 SHALL have, for each requester n: gnt<n>_o out 1 transfer accepted this cycle; rvalid<n>_o out 1 response; rdata<n>_o out DBITS read data.
REQ-006 SHALL have RAM-side ports: ram_addr_o out ABITS; ram_we_o out 1; ram_be_o out BBITS; ram_din_o out DBITS; ram_dout_i in DBITS (RAM read data, valid one cycle after address).

Function
REQ-007 SHALL grant at most one requester per cycle; gnt<n>_o combinational from req inputs and arbitration state, same cycle as request.
REQ-008 SHALL drive ram_addr_o/ram_we_o/ram_be_o/ram_din_o from the granted port; granted transfer = req&gnt high at a rising edge.
REQ-009 SHALL, with no grant, drive ram_we_o=0, ram_be_o=0, ram_addr_o=addr0_i, ram_din_o=wdata0_i.
REQ-010 SHALL force ram_be_o=0 when ram_we_o=0.
REQ-011 SHALL assert rvalid<n>_o exactly one cycle after every granted transfer of port n (reads and writes), for one cycle.
REQ-012 SHALL drive rdata<n>_o=ram_dout_i while rvalid<n>_o=1 after a read; rdata<n>_o=0 otherwise (including write responses).
REQ-013 SHALL hold a 1-bit last-grant register `last`, updated to n on each granted transfer of port n, unchanged in idle cycles.
REQ-014 SHALL, with one requester active, grant it every cycle (back-to-back, zero bubbles, throughput 1 transfer/cycle).
REQ-015 SHALL, on simultaneous requests, resolve per REQ-020/021; the loser's gnt is 0 and it SHALL hold its request stable until granted.
REQ-016 SHALL keep response order per port equal to grant order; at most one response outstanding system-wide.
REQ-017 SHALL allow a new grant in the same cycle a previous response is returned (pipelined).

Reset
REQ-018 SHALL, while rst_ni=0, asynchronously clear rvalid0_o, rvalid1_o, rdata0_o, rdata1_o to 0 and set last=1 (port 0 wins first contention); gnt/RAM outputs follow REQ-009 only after reset release; during reset gnt<n>_o=0 and ram_we_o=0.
REQ-019 SHALL drop any response pending at reset assertion; no rvalid after reset release without a new grant.

Configuration
REQ-020 With macro RL_RAM_ARB_RR_EN defined, contention SHALL be round-robin: grant port opposite to `last`.
REQ-021 Without RL_RAM_ARB_RR_EN, contention SHALL be fixed priority: port 0 always wins; `last` still maintained but unused for arbitration.

Verification
REQ-022 Reset mid-read: port0 read granted, rst_ni low next cycle -> rvalid0_o=0, rdata0_o=0, no rvalid after release.
REQ-023 Single port: port1 writes 0xDEADBEEF be=4'hF to addr 5, then reads addr 5 back-to-back -> gnt1_o=1 both cycles, rvalid1_o=1 on cycles +1 and +2, rdata1_o=0xDEADBEEF on second response.
REQ-024 Byte enables: write 0x11223344 be=4'h3 over 0xAABBCCDD at addr 7, read -> 0xAABB3344; idle cycle -> ram_be_o=0, ram_we_o=0.
REQ-025 Contention, RR_EN defined: both request continuously 4 cycles from reset -> grants 0,1,0,1; rvalid alternates one cycle later.
REQ-026 Contention, RR_EN undefined: both request 4 cycles -> gnt0_o=1 all 4, gnt1_o=0; drop req0 -> port1 granted next cycle.
REQ-027 Response isolation: port0 read addr 3 then port1 read addr 4 consecutive -> rvalid0_o then rvalid1_o, each only on own port, rdata of other port 0.

Source files
------------

// File: rtl/rl_ram_arb.sv
// rl_ram_arb: two-port arbiter in front of a single-port synchronous RAM.
//
// Each requester presents a word address, write flag, byte enables and write
// data. At most one requester is granted per cycle. The grant is combinational
// from the request inputs and the last-grant register. The granted transfer
// drives the RAM directly. Its response (rvalid, plus rdata for reads) comes
// back on the same port exactly one cycle later. A new grant may be issued in
// the same cycle as a response, so one requester alone gets one transfer per
// cycle.
//
// Configuration:
//   RL_RAM_ARB_RR_EN  defined   -> contention is round-robin (the port opposite
//                                  to the last granted one wins)
//                     undefined -> contention is fixed priority (port 0 wins)
//
// Parameters:
//   ABITS  RAM word-address width
//   DBITS  RAM data width
//   BBITS  byte-enable width, derived as (DBITS+7)/8
//
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   req<n>_i                        request from requester n
//   addr<n>_i, we<n>_i, be<n>_i     address, write flag, byte enables
//   wdata<n>_i                      write data
//   gnt<n>_o                        transfer of requester n accepted this cycle
//   rvalid<n>_o                     response for requester n (one cycle after grant)
//   rdata<n>_o                      read data while rvalid<n>_o after a read, else 0
//   ram_addr_o, ram_we_o, ram_be_o  RAM address, write enable, byte enables
//   ram_din_o                       RAM write data
//   ram_dout_i                      RAM read data, valid one cycle after address

module rl_ram_arb #(
    parameter int unsigned ABITS = 10,
    parameter int unsigned DBITS = 32,
    localparam int unsigned BBITS = (DBITS + 7) / 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic             req0_i,
    input  logic [ABITS-1:0] addr0_i,
    input  logic             we0_i,
    input  logic [BBITS-1:0] be0_i,
    input  logic [DBITS-1:0] wdata0_i,
    output logic             gnt0_o,
    output logic             rvalid0_o,
    output logic [DBITS-1:0] rdata0_o,

    input  logic             req1_i,
    input  logic [ABITS-1:0] addr1_i,
    input  logic             we1_i,
    input  logic [BBITS-1:0] be1_i,
    input  logic [DBITS-1:0] wdata1_i,
    output logic             gnt1_o,
    output logic             rvalid1_o,
    output logic [DBITS-1:0] rdata1_o,

    output logic [ABITS-1:0] ram_addr_o,
    output logic             ram_we_o,
    output logic [BBITS-1:0] ram_be_o,
    output logic [DBITS-1:0] ram_din_o,
    input  logic [DBITS-1:0] ram_dout_i
);

    logic             last_q;     // port of the most recent granted transfer
    logic             rvalid0_q;
    logic             rvalid1_q;
    logic             rd_q;       // the outstanding response belongs to a read
    logic             win0;       // port 0 wins when both request
    logic             gnt0;
    logic             gnt1;
    logic             ram_we;
    logic [BBITS-1:0] be_sel;

`ifdef RL_RAM_ARB_RR_EN
    // last_q == 1 means port 1 went last, so it is port 0's turn.
    assign win0 = last_q;
`else
    assign win0 = 1'b1;
    // last_q is still tracked but plays no part in fixed-priority arbitration.
    logic unused_last;
    assign unused_last = last_q;
`endif

    // Gating with rst_ni keeps grants (and thus RAM writes) off during reset.
    assign gnt0 = rst_ni & req0_i & (~req1_i | win0);
    assign gnt1 = rst_ni & req1_i & (~req0_i | ~win0);

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;

    // RAM side: port 0 fields are the idle default.
    always_comb begin
        ram_addr_o = addr0_i;
        ram_din_o  = wdata0_i;
        be_sel     = be0_i;
        ram_we     = 1'b0;
        if (gnt1) begin
            ram_addr_o = addr1_i;
            ram_din_o  = wdata1_i;
            be_sel     = be1_i;
            ram_we     = we1_i;
        end else if (gnt0) begin
            ram_we     = we0_i;
        end
        ram_we_o = ram_we;
        ram_be_o = ram_we ? be_sel : '0;
    end

    // Response tracking. A pending response is dropped by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q    <= 1'b1;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rd_q      <= 1'b0;
        end else begin
            rvalid0_q <= gnt0;
            rvalid1_q <= gnt1;
            rd_q      <= (gnt0 | gnt1) & ~ram_we;
            if (gnt0) begin
                last_q <= 1'b0;
            end else if (gnt1) begin
                last_q <= 1'b1;
            end
        end
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;

    // RAM read data arrives one cycle after the address, aligned with rvalid.
    assign rdata0_o = (rvalid0_q & rd_q) ? ram_dout_i : '0;
    assign rdata1_o = (rvalid1_q & rd_q) ? ram_dout_i : '0;

endmodule

// File: tb/tb_rl_ram_arb.sv
// Directed-vector bench for rl_ram_arb with a behavioural synchronous RAM.
// Each table row is one clock cycle: inputs are applied just after a rising
// edge and all outputs are compared at the following falling edge.

module tb_rl_ram_arb;

    localparam int unsigned ABITS = 10;
    localparam int unsigned DBITS = 32;
    localparam int unsigned BBITS = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             req0_i, req1_i, we0_i, we1_i;
    logic [ABITS-1:0] addr0_i, addr1_i;
    logic [BBITS-1:0] be0_i, be1_i;
    logic [DBITS-1:0] wdata0_i, wdata1_i;
    logic             gnt0_o, gnt1_o, rvalid0_o, rvalid1_o;
    logic [DBITS-1:0] rdata0_o, rdata1_o;
    logic [ABITS-1:0] ram_addr_o;
    logic             ram_we_o;
    logic [BBITS-1:0] ram_be_o;
    logic [DBITS-1:0] ram_din_o;
    logic [DBITS-1:0] ram_dout_i = '0;

    int checks = 0;
    int errors = 0;

    rl_ram_arb #(.ABITS(ABITS), .DBITS(DBITS)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req0_i(req0_i), .addr0_i(addr0_i), .we0_i(we0_i), .be0_i(be0_i),
        .wdata0_i(wdata0_i), .gnt0_o(gnt0_o), .rvalid0_o(rvalid0_o), .rdata0_o(rdata0_o),
        .req1_i(req1_i), .addr1_i(addr1_i), .we1_i(we1_i), .be1_i(be1_i),
        .wdata1_i(wdata1_i), .gnt1_o(gnt1_o), .rvalid1_o(rvalid1_o), .rdata1_o(rdata1_o),
        .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
        .ram_din_o(ram_din_o), .ram_dout_i(ram_dout_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural RAM: byte-masked write, read data one cycle after address.
    logic [DBITS-1:0] mem [0:(1<<ABITS)-1];
    always @(posedge clk_i) begin
        if (ram_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_be_o[b]) mem[ram_addr_o][8*b +: 8] <= ram_din_o[8*b +: 8];
            end
        end
        ram_dout_i <= mem[ram_addr_o];
    end

    typedef struct {
        logic             r0, w0, r1, w1;
        logic [ABITS-1:0] a0, a1;
        logic [BBITS-1:0] b0, b1;
        logic [DBITS-1:0] d0, d1;
        logic             eg0, eg1, ewe;
        logic [BBITS-1:0] ebe;
        logic [ABITS-1:0] ea;
        logic             ev0, ev1;
        logic [DBITS-1:0] ed0, ed1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic r0, input logic w0, input int a0, input logic [3:0] b0,
        input logic [31:0] d0,
        input logic r1, input logic w1, input int a1, input logic [3:0] b1,
        input logic [31:0] d1,
        input logic eg0, input logic eg1, input logic ewe, input logic [3:0] ebe,
        input int ea,
        input logic ev0, input logic [31:0] ed0, input logic ev1, input logic [31:0] ed1);
        vec_t t;
        t.r0 = r0; t.w0 = w0; t.a0 = a0[ABITS-1:0]; t.b0 = b0; t.d0 = d0;
        t.r1 = r1; t.w1 = w1; t.a1 = a1[ABITS-1:0]; t.b1 = b1; t.d1 = d1;
        t.eg0 = eg0; t.eg1 = eg1; t.ewe = ewe; t.ebe = ebe; t.ea = ea[ABITS-1:0];
        t.ev0 = ev0; t.ed0 = ed0; t.ev1 = ev1; t.ed1 = ed1;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        req0_i = t.r0; we0_i = t.w0; addr0_i = t.a0; be0_i = t.b0; wdata0_i = t.d0;
        req1_i = t.r1; we1_i = t.w1; addr1_i = t.a1; be1_i = t.b1; wdata1_i = t.d1;
    endtask

    task automatic idle_inputs();
        req0_i = 0; we0_i = 0; addr0_i = '0; be0_i = '0; wdata0_i = '0;
        req1_i = 0; we1_i = 0; addr1_i = '0; be1_i = '0; wdata1_i = '0;
    endtask

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] R3 = 32'h33333333;
    localparam logic [31:0] R4 = 32'h44444444;

    initial begin
        // Columns: port0 {req,we,addr,be,wdata} port1 {req,we,addr,be,wdata}
        //          exp {gnt0,gnt1,ram_we,ram_be,ram_addr} {rvalid0,rdata0,rvalid1,rdata1}
        vecs.push_back(v(0,0,0,4'h0,0,           0,0,0,4'h0,0,  0,0,0,4'h0,0, 0,0, 0,0));
        // port 1 write then back-to-back read of addr 5
        vecs.push_back(v(0,0,0,4'h0,0,           1,1,5,4'hF,DB, 0,1,1,4'hF,5, 0,0, 0,0));
        vecs.push_back(v(0,0,0,4'h0,0,           1,0,5,4'hF,0,  0,1,0,4'h0,5, 0,0, 1,0));
        // idle with port-0 write fields present: nothing reaches the RAM
        vecs.push_back(v(0,1,9,4'hF,32'h5555,    0,0,0,4'h0,0,  0,0,0,4'h0,9, 0,0, 1,DB));
        // partial byte write at addr 7
        vecs.push_back(v(1,1,7,4'hF,32'hAABBCCDD,0,0,0,4'h0,0,  1,0,1,4'hF,7, 0,0, 0,0));
        vecs.push_back(v(1,1,7,4'h3,32'h11223344,0,0,0,4'h0,0,  1,0,1,4'h3,7, 1,0, 0,0));
        vecs.push_back(v(1,0,7,4'h3,0,           0,0,0,4'h0,0,  1,0,0,4'h0,7, 1,0, 0,0));
        vecs.push_back(v(0,0,0,4'h0,0,           0,0,0,4'h0,0,  0,0,0,4'h0,0, 1,32'hAABB3344, 0,0));
        // response isolation: seed addr 3/4, then read them on opposite ports
        vecs.push_back(v(1,1,3,4'hF,R3,          0,0,0,4'h0,0,  1,0,1,4'hF,3, 0,0, 0,0));
        vecs.push_back(v(0,0,0,4'h0,0,           1,1,4,4'hF,R4, 0,1,1,4'hF,4, 1,0, 0,0));
        vecs.push_back(v(1,0,3,4'h0,0,           0,0,0,4'h0,0,  1,0,0,4'h0,3, 0,0, 1,0));
        vecs.push_back(v(0,0,0,4'h0,0,           1,0,4,4'h0,0,  0,1,0,4'h0,4, 1,R3, 0,0));
        vecs.push_back(v(0,0,0,4'h0,0,           0,0,0,4'h0,0,  0,0,0,4'h0,0, 0,0, 1,R4));
        // contention: both read for 4 cycles; last grant so far was port 1
`ifdef RL_RAM_ARB_RR_EN
        vecs.push_back(v(1,0,3,4'h0,0,           1,0,4,4'h0,0,  1,0,0,4'h0,3, 0,0, 0,0));
        vecs.push_back(v(1,0,3,4'h0,0,           1,0,4,4'h0,0,  0,1,0,4'h0,4, 1,R3, 0,0));
        vecs.push_back(v(1,0,3,4'h0,0,           1,0,4,4'h0,0,  1,0,0,4'h0,3, 0,0, 1,R4));
        vecs.push_back(v(1,0,3,4'h0,0,           1,0,4,4'h0,0,  0,1,0,4'h0,4, 1,R3, 0,0));
        vecs.push_back(v(1,0,3,4'h0,0,           0,0,4,4'h0,0,  1,0,0,4'h0,3, 0,0, 1,R4));
        vecs.push_back(v(0,0,0,4'h0,0,           0,0,0,4'h0,0,  0,0,0,4'h0,0, 1,R3, 0,0));
`else
        vecs.push_back(v(1,0,3,4'h0,0,           1,0,4,4'h0,0,  1,0,0,4'h0,3, 0,0, 0,0));
        vecs.push_back(v(1,0,3,4'h0,0,           1,0,4,4'h0,0,  1,0,0,4'h0,3, 1,R3, 0,0));
        vecs.push_back(v(1,0,3,4'h0,0,           1,0,4,4'h0,0,  1,0,0,4'h0,3, 1,R3, 0,0));
        vecs.push_back(v(1,0,3,4'h0,0,           1,0,4,4'h0,0,  1,0,0,4'h0,3, 1,R3, 0,0));
        vecs.push_back(v(0,0,3,4'h0,0,           1,0,4,4'h0,0,  0,1,0,4'h0,4, 1,R3, 0,0));
        vecs.push_back(v(0,0,0,4'h0,0,           0,0,0,4'h0,0,  0,0,0,4'h0,0, 0,0, 1,R4));
`endif

        // Reset state, with a port-0 write request held during reset.
        idle_inputs();
        req0_i = 1; we0_i = 1; be0_i = 4'hF;
        #3;
        chk("reset gnt0", 32'(gnt0_o), 0);
        chk("reset ram_we", 32'(ram_we_o), 0);
        chk("reset ram_be", 32'(ram_be_o), 0);
        chk("reset rvalid0", 32'(rvalid0_o), 0);
        chk("reset rvalid1", 32'(rvalid1_o), 0);
        chk("reset rdata0", rdata0_o, 0);
        chk("reset rdata1", rdata1_o, 0);
        #9;
        idle_inputs();
        rst_ni = 1;

        foreach (vecs[i]) begin
            @(posedge clk_i);
            #1;
            drive(vecs[i]);
            @(negedge clk_i);
            chk($sformatf("row%0d gnt0", i), 32'(gnt0_o), 32'(vecs[i].eg0));
            chk($sformatf("row%0d gnt1", i), 32'(gnt1_o), 32'(vecs[i].eg1));
            chk($sformatf("row%0d ram_we", i), 32'(ram_we_o), 32'(vecs[i].ewe));
            chk($sformatf("row%0d ram_be", i), 32'(ram_be_o), 32'(vecs[i].ebe));
            chk($sformatf("row%0d ram_addr", i), 32'(ram_addr_o), 32'(vecs[i].ea));
            chk($sformatf("row%0d rvalid0", i), 32'(rvalid0_o), 32'(vecs[i].ev0));
            chk($sformatf("row%0d rdata0", i), rdata0_o, vecs[i].ed0);
            chk($sformatf("row%0d rvalid1", i), 32'(rvalid1_o), 32'(vecs[i].ev1));
            chk($sformatf("row%0d rdata1", i), rdata1_o, vecs[i].ed1);
        end

        // Reset mid-read: port 0 read of addr 3 granted, reset asserted after.
        @(posedge clk_i);
        #1;
        idle_inputs();
        req0_i = 1; addr0_i = 3;
        @(negedge clk_i);
        chk("midrst gnt0 before", 32'(gnt0_o), 1);
        @(posedge clk_i);
        #1;
        chk("midrst rvalid0 pending", 32'(rvalid0_o), 1);
        rst_ni = 0;
        #1;
        chk("midrst rvalid0", 32'(rvalid0_o), 0);
        chk("midrst rdata0", rdata0_o, 0);
        chk("midrst gnt0", 32'(gnt0_o), 0);
        @(negedge clk_i);
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk($sformatf("postrst%0d rvalid0", c), 32'(rvalid0_o), 0);
            chk($sformatf("postrst%0d rvalid1", c), 32'(rvalid1_o), 0);
        end

        // First contention after reset goes to port 0 in either mode.
        @(posedge clk_i);
        #1;
        req0_i = 1; addr0_i = 3; req1_i = 1; addr1_i = 4;
        @(negedge clk_i);
        chk("postrst contend gnt0", 32'(gnt0_o), 1);
        chk("postrst contend gnt1", 32'(gnt1_o), 0);
        @(posedge clk_i);
        #1;
        req0_i = 0;
        @(negedge clk_i);
        chk("postrst gnt1", 32'(gnt1_o), 1);
        chk("postrst rvalid0", 32'(rvalid0_o), 1);
        chk("postrst rdata0", rdata0_o, R3);
        @(posedge clk_i);
        #1;
        idle_inputs();
        @(negedge clk_i);
        chk("postrst rvalid1", 32'(rvalid1_o), 1);
        chk("postrst rdata1", rdata1_o, R4);
        chk("postrst rvalid0 off", 32'(rvalid0_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
